// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampling 8N1-style UART receive framer, LSB first.
// Synchronises rxd, validates the start bit at its midpoint, samples each
// data bit at its midpoint and checks the stop bit.
//
// Output handshake: rec_valid is a one-cycle strobe with no ready. rec_data
// is updated in the same cycle rec_valid rises and holds until the next good
// frame. A consumer that misses the strobe loses it. frame_err is a one-cycle
// strobe that never coincides with rec_valid and leaves rec_data untouched.
module uart_rx_framer #(
  parameter int DATA_BITS = 8,
  parameter int OS_FACTOR = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rec_data,
  output logic                 rec_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int OW = $clog2(OS_FACTOR);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Start is confirmed when the incremented count reaches half a bit minus one,
  // so the detecting tick plus these ticks lands near the start-bit midpoint.
  localparam logic [OW-1:0] HALF_M1  = OW'(OS_FACTOR / 2 - 1);
  localparam logic [OW-1:0] LAST_OS  = OW'(OS_FACTOR - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [OW-1:0]        os_cnt_q, os_cnt_d, os_cnt_inc;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rec_data_d;
  logic                 rec_valid_d;
  logic                 frame_err_d;
  logic [1:0]           sync_q;
  logic                 rxd_s;

  // Two-flop synchroniser for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rxd_s      = sync_q[1];
  assign os_cnt_inc = os_cnt_q + OW'(1);

  // State, counters, shift register and registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rec_data  <= '0;
      rec_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rec_data  <= rec_data_d;
      rec_valid <= rec_valid_d;
      frame_err <= frame_err_d;
    end
  end

  // Next-state logic; everything advances only on os_tick.
  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rec_data_d  = rec_data;
    rec_valid_d = 1'b0;
    frame_err_d = 1'b0;
    if (os_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxd_s) begin
            state_d  = S_START;
            os_cnt_d = '0;
          end
        end
        S_START: begin
          if (os_cnt_inc == HALF_M1) begin
            if (rxd_s) begin
              // Line went back high before the midpoint: treat as a glitch.
              state_d = S_IDLE;
            end else begin
              state_d   = S_DATA;
              os_cnt_d  = '0;
              bit_cnt_d = '0;
            end
          end else begin
            os_cnt_d = os_cnt_inc;
          end
        end
        S_DATA: begin
          if (os_cnt_q == LAST_OS) begin
            shift_d  = {rxd_s, shift_q[DATA_BITS-1:1]};
            os_cnt_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            os_cnt_d = os_cnt_inc;
          end
        end
        S_STOP: begin
          if (os_cnt_q == LAST_OS) begin
            os_cnt_d = '0;
            if (rxd_s) begin
              rec_data_d  = shift_q;
              rec_valid_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end else begin
            os_cnt_d = os_cnt_inc;
          end
        end
        S_BREAK: begin
          // A held-low line must return high before a new start is accepted.
          if (rxd_s) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign rx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Testbench for uart_rx_framer: serial driver, os_tick generator, and a
// scoreboard that pairs each rec_valid strobe with the byte that was sent.
module tb_uart_rx_framer;

  localparam int DATA_BITS = 8;
  localparam int OS_FACTOR = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       os_tick;
  logic       rxd;
  logic [7:0] rec_data;
  logic       rec_valid;
  logic       frame_err;
  logic       rx_busy;

  always #5 clk = ~clk;

  uart_rx_framer #(
    .DATA_BITS(DATA_BITS),
    .OS_FACTOR(OS_FACTOR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .os_tick  (os_tick),
    .rxd      (rxd),
    .rec_data (rec_data),
    .rec_valid(rec_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  // ---------------- bookkeeping ----------------
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  int         exp_err = 0;
  int         valid_cnt = 0;
  int         err_cnt = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         last_valid_cyc = 0;
  logic [7:0] last_good = 8'h00;
  int         tick_div = 4;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- os_tick generator ----------------
  initial begin : tick_gen
    int cnt;
    cnt = 0;
    os_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_div <= 1) begin
        os_tick = 1'b1;
      end else begin
        os_tick = (cnt == 0);
        cnt = (cnt + 1) % tick_div;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin : monitor
    logic       prev_valid;
    logic       prev_err;
    logic [7:0] exp;
    prev_valid = 1'b0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rec_valid === 1'b1) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        check_eq("valid_width", prev_valid, 0);
        check_eq("valid_err_excl", frame_err, 0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid_qsize", exp_q.size(), 1);
        end else begin
          exp = exp_q.pop_front();
          check_eq("rec_data", rec_data, exp);
          last_good = exp;
        end
      end
      if (frame_err === 1'b1) begin
        err_cnt++;
        check_eq("err_width", prev_err, 0);
        check_eq("err_expected", exp_err > 0, 1);
        if (exp_err > 0) exp_err--;
        check_eq("rec_data_hold", rec_data, last_good);
      end
      prev_valid = rec_valid;
      prev_err = frame_err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bit_clks();
    return OS_FACTOR * ((tick_div < 1) ? 1 : tick_div);
  endfunction

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    if (stop_bit) exp_q.push_back(data);
    else exp_err++;
    start_cyc = cyc;
    rxd = 1'b0;
    wait_clks(bit_clks());
    for (int i = 0; i < DATA_BITS; i++) begin
      rxd = data[i];
      wait_clks(bit_clks());
    end
    rxd = stop_bit;
    wait_clks(bit_clks());
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    wait_clks(n * bit_clks());
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int         v0;
    int         e0;
    logic [7:0] d;
    rst = 1'b1;
    rxd = 1'b1;
    wait_clks(3);
    check_eq("reset_rec_data", rec_data, 0);
    check_eq("reset_rec_valid", rec_valid, 0);
    check_eq("reset_frame_err", frame_err, 0);
    check_eq("reset_rx_busy", rx_busy, 0);
    rst = 1'b0;
    idle_bits(2);

    // Good frame, tick every 4 clk.
    send_frame(8'hA5, 1'b1);
    check_eq("good_busy_after_stop", rx_busy, 0);
    check_eq("good_rec_data", rec_data, 8'hA5);
    check_eq("good_valid_cnt", valid_cnt, 1);
    check_eq("good_err_cnt", err_cnt, 0);
    idle_bits(2);

    // Start glitch: 4 ticks low then high again.
    v0 = valid_cnt;
    e0 = err_cnt;
    rxd = 1'b0;
    wait_clks(4 * tick_div);
    rxd = 1'b1;
    check_eq("glitch_busy_during", rx_busy, 1);
    wait_clks(28);
    check_eq("glitch_busy_after", rx_busy, 0);
    idle_bits(2);
    check_eq("glitch_valid_cnt", valid_cnt, v0);
    check_eq("glitch_err_cnt", err_cnt, e0);

    // Framing error: 0x3C with low stop bit, line held low for 40 more ticks.
    send_frame(8'h3C, 1'b0);
    wait_clks(40 * tick_div);
    check_eq("ferr_err_cnt", err_cnt, e0 + 1);
    check_eq("ferr_valid_cnt", valid_cnt, v0);
    check_eq("ferr_rec_data", rec_data, 8'hA5);
    check_eq("ferr_busy_break", rx_busy, 1);
    rxd = 1'b1;
    wait_clks(10);
    check_eq("ferr_busy_released", rx_busy, 0);
    idle_bits(4);
    check_eq("ferr_no_spurious_err", err_cnt, e0 + 1);
    check_eq("ferr_no_spurious_valid", valid_cnt, v0);

    // Back-to-back frames with no idle gap.
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_bits(2);
    check_eq("b2b_valid_cnt", valid_cnt, v0 + 2);
    check_eq("b2b_rec_data", rec_data, 8'hFF);
    check_eq("b2b_queue_drained", exp_q.size(), 0);

    // Continuous tick. Latency from driving the start edge to the strobe:
    // 2 sync flops + 1 detecting tick + 151 ticks to the stop sample = 154.
    tick_div = 1;
    idle_bits(2);
    send_frame(8'h81, 1'b1);
    idle_bits(1);
    check_eq("cont_rec_data", rec_data, 8'h81);
    check_eq("cont_latency", last_valid_cyc - start_cyc, 154);

    // Reset during data bit 3 of 0x5A.
    tick_div = 4;
    idle_bits(2);
    v0 = valid_cnt;
    e0 = err_cnt;
    d = 8'h5A;
    rxd = 1'b0;
    wait_clks(bit_clks());
    for (int i = 0; i < 3; i++) begin
      rxd = d[i];
      wait_clks(bit_clks());
    end
    rxd = d[3];
    wait_clks(bit_clks() / 2);
    check_eq("rstmid_busy_before", rx_busy, 1);
    rst = 1'b1;
    wait_clks(1);
    check_eq("rstmid_rec_data", rec_data, 0);
    check_eq("rstmid_rec_valid", rec_valid, 0);
    check_eq("rstmid_frame_err", frame_err, 0);
    check_eq("rstmid_rx_busy", rx_busy, 0);
    rst = 1'b0;
    last_good = 8'h00;
    idle_bits(12);
    check_eq("rstmid_no_valid", valid_cnt, v0);
    check_eq("rstmid_no_err", err_cnt, e0);
    send_frame(8'h5A, 1'b1);
    idle_bits(2);
    check_eq("rstmid_after_valid_cnt", valid_cnt, v0 + 1);
    check_eq("rstmid_after_rec_data", rec_data, 8'h5A);

    // Final scoreboard state.
    check_eq("final_queue_empty", exp_q.size(), 0);
    check_eq("final_err_pending", exp_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
